// File: rtl/fp32_pkg.sv
// Shared fp32 constants, field geometry and the divider FSM state encoding.
package fp32_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;

  // Quotient carries two extra bits below the 24-bit mantissa for guard/sticky.
  localparam int QUO_W      = 26;
  localparam int REM_W      = 25;
  localparam int DIV_CYCLES = 26;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIV,
    ROUND,
    DONE
  } state_e;

endpackage

// File: rtl/fp32_divide_seq_if.sv
// Request/response bundle of the iterative fp32 divider.
interface fp32_divide_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, output A, output B,
                  input busy, input done, input result);
  modport slave  (input start, input A, input B,
                  output busy, output done, output result);
endinterface

// File: rtl/fp32_unpack.sv
// Combinational operand classifier: splits an fp32 word and flags zero/inf/NaN.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]         word,
  output logic                sign,
  output logic [FP_EXP_W-1:0] exp,
  output logic [FP_MAN_W:0]   mant,
  output logic                is_zero,
  output logic                is_inf,
  output logic                is_nan
);

  logic frac_nz;

  assign sign    = word[SIGN_POS];
  assign exp     = word[EXP_MSB:EXP_LSB];
  assign mant    = {1'b1, word[FP_MAN_W-1:0]};
  assign frac_nz = |word[FP_MAN_W-1:0];

  // Subnormals are flushed: any zero exponent field reads as zero.
  assign is_zero = (exp == '0);
  assign is_inf  = (exp == '1) && !frac_nz;
  assign is_nan  = (exp == '1) && frac_nz;

endmodule

// File: rtl/fp32_divide_seq.sv
// Iterative fp32 divider: radix-2 restoring mantissa division, RNE rounding,
// fixed 29-cycle latency regardless of operand class.
module fp32_divide_seq
  import fp32_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  fp32_divide_seq_if.slave  bus
);

  localparam int WORD_W = 1 + EXP_W + MAN_W;
  localparam logic signed [9:0] E_BIAS = 10'(EXP_BIAS);
  localparam logic signed [9:0] E_MAX  = 10'(EXP_MAX);

  state_e                   state_q, state_d;
  logic [WORD_W-1:0]        a_q, a_d;
  logic [WORD_W-1:0]        b_q, b_d;
  logic                     sign_q, sign_d;
  logic signed [9:0]        exp_q, exp_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [MAN_W:0]           mb_q, mb_d;
  logic [QUO_W-1:0]         quo_q, quo_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [WORD_W-1:0]        result_q, result_d;

  logic                     ua_sign, ub_sign;
  logic [EXP_W-1:0]         ua_exp, ub_exp;
  logic [MAN_W:0]           ua_mant, ub_mant;
  logic                     ua_zero, ua_inf, ua_nan;
  logic                     ub_zero, ub_inf, ub_nan;

  logic [REM_W-1:0]         divisor;
  logic                     rem_ge;
  logic [REM_W-1:0]         rem_next;
  logic                     spec_nan, spec_inf, spec_zero;

  fp32_unpack u_unpack_a (
    .word    (a_q),
    .sign    (ua_sign),
    .exp     (ua_exp),
    .mant    (ua_mant),
    .is_zero (ua_zero),
    .is_inf  (ua_inf),
    .is_nan  (ua_nan)
  );

  fp32_unpack u_unpack_b (
    .word    (b_q),
    .sign    (ub_sign),
    .exp     (ub_exp),
    .mant    (ub_mant),
    .is_zero (ub_zero),
    .is_inf  (ub_inf),
    .is_nan  (ub_nan)
  );

  // Normalize, round to nearest even and range-check the raw quotient.
  function automatic logic [WORD_W-1:0] round_pack(
    input logic                 s,
    input logic signed [9:0]    e_in,
    input logic [QUO_W-1:0]     q,
    input logic                 rem_nz
  );
    logic [MAN_W:0]    m;
    logic [MAN_W+1:0]  r;
    logic              g;
    logic              st;
    logic              inc;
    logic signed [9:0] e;
    if (q[QUO_W-1]) begin
      m  = q[QUO_W-1:2];
      g  = q[1];
      st = q[0] | rem_nz;
      e  = e_in;
    end else begin
      m  = q[QUO_W-2:1];
      g  = q[0];
      st = rem_nz;
      e  = e_in - 10'sd1;
    end
    inc = g & (st | m[0]);
    r   = {1'b0, m} + {{(MAN_W+1){1'b0}}, inc};
    if (r[MAN_W+1]) begin
      m = r[MAN_W+1:1];
      e = e + 10'sd1;
    end else begin
      m = r[MAN_W:0];
    end
    if (e >= E_MAX)
      return {s, POS_INF[WORD_W-2:0]};
    else if (e <= 10'sd0)
      return {s, {(WORD_W-1){1'b0}}};
    else
      return {s, e[EXP_W-1:0], m[MAN_W-1:0]};
  endfunction

  assign divisor  = {1'b0, mb_q};
  assign rem_ge   = (rem_q >= divisor);
  assign rem_next = rem_ge ? (rem_q - divisor) : rem_q;

  assign spec_nan  = ua_nan | ub_nan | (ua_zero & ub_zero) | (ua_inf & ub_inf);
  assign spec_inf  = ua_inf | ub_zero;
  assign spec_zero = ua_zero | ub_inf;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    mb_d     = mb_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          state_d = UNPACK;
        end else begin
          state_d = IDLE;
        end
      end
      UNPACK: begin
        sign_d  = ua_sign ^ ub_sign;
        exp_d   = $signed({2'b00, ua_exp}) - $signed({2'b00, ub_exp}) + E_BIAS;
        rem_d   = {1'b0, ua_mant};
        mb_d    = ub_mant;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        rem_d = rem_next << 1;
        quo_d = {quo_q[QUO_W-2:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_CYCLES - 1))
          state_d = ROUND;
      end
      ROUND: begin
        if (spec_nan)
          result_d = QNAN;
        else if (spec_inf)
          result_d = {sign_q, POS_INF[WORD_W-2:0]};
        else if (spec_zero)
          result_d = {sign_q, {(WORD_W-1){1'b0}}};
        else
          result_d = round_pack(sign_q, exp_q, quo_q, |rem_q);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      mb_q     <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      mb_q     <= mb_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == UNPACK) || (state_q == DIV) || (state_q == ROUND);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_fp32_divide_seq.sv
// Scoreboard bench for fp32_divide_seq: directed operands with hand-derived quotients.
module tb_fp32_divide_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp32_divide_seq_if bus();

  fp32_divide_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   chk = 0;
  int   err = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: cycle counter plus scoreboard pop on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk++;
          err++;
          $display("FAIL unexpected_done actual=1 required=0 at cycle %0d result=%h", cyc, bus.result);
        end else begin
          e = sb.pop_front();
          check(e.name, bus.result, e.res);
          check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
          check({e.name, "_busy_on_done"}, {31'd0, bus.busy}, 32'd0);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        chk++;
        err++;
        $display("FAIL %s_missing_done actual=none required=done at cycle %0d", e.name, e.due);
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input string name, input bit push);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    if (push) sb.push_back('{res, cyc + 29, name});
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input string name);
    @(negedge clk);
    #1;
    start_op(a, b, res, name, 1'b1);
    @(negedge clk);
    #1;
    check({name, "_busy_after_start"}, {31'd0, bus.busy}, 32'd1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, bus.busy}, 32'd0);
    check("reset_done",   {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'h0);
    rst = 1'b0;

    run(32'h40C00000, 32'h40000000, 32'h40400000, "six_div_two");
    run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "one_div_three");
    run(32'h3F800000, 32'h3F800000, 32'h3F800000, "one_div_one");

    run(32'h3F800000, 32'h00000000, 32'h7F800000, "x_div_zero");
    run(32'h00000000, 32'h00000000, 32'h7FC00000, "zero_div_zero");
    run(32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf_div_inf");
    run(32'hC0000000, 32'h7F800000, 32'h80000000, "neg_div_inf");
    run(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_div_one");
    run(32'h00000001, 32'h3F800000, 32'h00000000, "subnormal_flush");

    run(32'h7F7FFFFF, 32'h00800000, 32'h7F800000, "overflow_pos");
    run(32'h00800000, 32'h40000000, 32'h00000000, "underflow_flush");
    run(32'hBF800000, 32'h00800000, 32'hFE800000, "neg_one_div_min_normal");
    run(32'hFF7FFFFF, 32'h3F000000, 32'hFF800000, "overflow_neg");

    // start held during DIV must be ignored
    @(negedge clk);
    #1;
    start_op(32'h41200000, 32'h40000000, 32'h40A00000, "start_held", 1'b1);
    repeat (6) @(negedge clk);
    #1;
    bus.A     = 32'h3F800000;
    bus.B     = 32'h40400000;
    bus.start = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // asynchronous reset in DIV cycle 10 aborts the operation
    @(negedge clk);
    #1;
    start_op(32'h3F800000, 32'h40400000, 32'h0, "aborted", 1'b0);
    repeat (11) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy",   {31'd0, bus.busy}, 32'd0);
    check("abort_done",   {31'd0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("abort_idle_busy", {31'd0, bus.busy}, 32'd0);

    run(32'h40C00000, 32'h40000000, 32'h40400000, "after_reset");

    // back-to-back: second start issued in the done cycle of the first
    @(negedge clk);
    #1;
    start_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "b2b_first", 1'b1);
    for (int i = 0; i < 40 && !bus.done; i++) begin
      @(negedge clk);
      #1;
    end
    if (!bus.done) begin
      chk++;
      err++;
      $display("FAIL b2b_wait_done actual=0 required=1");
    end
    start_op(32'h41200000, 32'h40A00000, 32'h40000000, "b2b_second", 1'b1);
    repeat (20) @(negedge clk);
    #1;
    check("b2b_first_held", bus.result, 32'h3EAAAAAB);
    wait_idle();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
